// File: rtl/step_sequencer.sv
// step_sequencer: programmable multi-channel step sequencer.
// A writable NUM_CH x STEPS pattern memory of {gate, note} entries is stepped
// through at a rate of one step every (tempo_div+1) clocks while run is high.
// Optional build macro: TRANSPOSE_EN (per-channel signed semitone offset with
// saturation applied to loaded notes). When undefined, transpose is ignored.
module step_sequencer #(
  parameter int NUM_CH = 4,
  parameter int NOTE_W = 6,
  parameter int STEPS  = 16,
  parameter int STEP_W = 4,
  parameter int DIV_W  = 24,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     run,
  input  logic [DIV_W-1:0]         tempo_div,
  input  logic [STEP_W-1:0]        last_step,
  input  logic                     wr_en,
  input  logic [CH_W-1:0]          wr_ch,
  input  logic [STEP_W-1:0]        wr_step,
  input  logic [NOTE_W-1:0]        wr_note,
  input  logic                     wr_gate,
  input  logic [NUM_CH*6-1:0]      transpose,
  output logic [NUM_CH*NOTE_W-1:0] note_out,
  output logic [NUM_CH-1:0]        gate_out,
  output logic [STEP_W-1:0]        step_idx,
  output logic                     step_pulse,
  output logic                     beat_led
);

  // Pattern memory entry layout: {gate, note}
  logic [NOTE_W:0]       mem [NUM_CH][STEPS];

  logic [DIV_W-1:0]      cnt_p0;
  logic                  run_p0;
  logic                  advance;
  logic [STEP_W-1:0]     nxt_step;
  logic [NUM_CH-1:0]     ld_gate;
  logic [NUM_CH-1:0]     rs_gate;
  logic [NOTE_W-1:0]     ld_note [NUM_CH];

`ifdef TRANSPOSE_EN
  localparam logic signed [NOTE_W+1:0] NOTE_MIN = (NOTE_W+2)'(1);
  localparam logic signed [NOTE_W+1:0] NOTE_MAX = (NOTE_W+2)'((1 << NOTE_W) - 1);

  // Clamp a widened transposed note into the playable range 1..2^NOTE_W-1
  function automatic logic [NOTE_W-1:0] sat_note(input logic signed [NOTE_W+1:0] v);
    if (v < NOTE_MIN)      return NOTE_W'(1);
    else if (v > NOTE_MAX) return '1;
    else                   return v[NOTE_W-1:0];
  endfunction

  // Rests (note 0) are never transposed; anything else is offset then clamped
  function automatic logic [NOTE_W-1:0] transpose_note(input logic [NOTE_W-1:0] n,
                                                       input logic signed [5:0] t);
    logic signed [NOTE_W+1:0] sum;
    sum = $signed({2'b00, n}) + $signed({{(NOTE_W-4){t[5]}}, t});
    if (n == '0) return '0;
    return sat_note(sum);
  endfunction
`else
  logic unused_transpose;
  assign unused_transpose = ^transpose;
`endif

  assign advance  = run && (cnt_p0 >= tempo_div);
  assign nxt_step = (step_idx >= last_step) ? '0 : step_idx + STEP_W'(1);

  // Pattern read: entry for the upcoming step, and the current step for gate restore
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      ld_gate[c] = mem[c][nxt_step][NOTE_W];
      rs_gate[c] = mem[c][step_idx][NOTE_W];
`ifdef TRANSPOSE_EN
      ld_note[c] = transpose_note(mem[c][nxt_step][NOTE_W-1:0], transpose[c*6 +: 6]);
`else
      ld_note[c] = mem[c][nxt_step][NOTE_W-1:0];
`endif
    end
  end

  // Tick counter: counts while running, clears after the advance cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_p0 <= '0;
    end else if (run) begin
      if (cnt_p0 >= tempo_div) cnt_p0 <= '0;
      else                     cnt_p0 <= cnt_p0 + DIV_W'(1);
    end
  end

  // Step position, strobes and per-channel note/gate outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      step_idx   <= '0;
      step_pulse <= 1'b0;
      beat_led   <= 1'b0;
      gate_out   <= '0;
      note_out   <= '0;
      run_p0     <= 1'b0;
    end else begin
      run_p0 <= run;
      if (advance) begin
        step_idx   <= nxt_step;
        step_pulse <= 1'b1;
        beat_led   <= ~beat_led;
        gate_out   <= ld_gate;
        for (int c = 0; c < NUM_CH; c++) begin
          // Gate-off steps leave the previous note sustaining
          if (ld_gate[c]) note_out[c*NOTE_W +: NOTE_W] <= ld_note[c];
        end
      end else begin
        step_pulse <= 1'b0;
        if (!run)        gate_out <= '0;
        else if (!run_p0) gate_out <= rs_gate;
      end
    end
  end

  // Pattern memory writes; out-of-range channels are dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++)
        for (int s = 0; s < STEPS; s++)
          mem[c][s] <= '0;
    end else if (wr_en && (int'(wr_ch) < NUM_CH)) begin
      mem[wr_ch][wr_step] <= {wr_gate, wr_note};
    end
  end

endmodule

// File: tb/tb_step_sequencer.sv
// tb_step_sequencer: randomized and directed stimulus for step_sequencer,
// checked every cycle against a behavioural reference model.
module tb_step_sequencer;
  localparam int NUM_CH = 4;
  localparam int NOTE_W = 6;
  localparam int STEPS  = 16;
  localparam int STEP_W = 4;
  localparam int DIV_W  = 24;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     rst, run, wr_en, wr_gate;
  logic [DIV_W-1:0]         tempo_div;
  logic [STEP_W-1:0]        last_step, wr_step;
  logic [1:0]               wr_ch;
  logic [NOTE_W-1:0]        wr_note;
  logic [NUM_CH*6-1:0]      transpose;
  logic [NUM_CH*NOTE_W-1:0] note_out;
  logic [NUM_CH-1:0]        gate_out;
  logic [STEP_W-1:0]        step_idx;
  logic                     step_pulse, beat_led;

  step_sequencer #(.NUM_CH(NUM_CH), .NOTE_W(NOTE_W), .STEPS(STEPS),
                   .STEP_W(STEP_W), .DIV_W(DIV_W)) dut (
    .clk(clk), .rst(rst), .run(run), .tempo_div(tempo_div), .last_step(last_step),
    .wr_en(wr_en), .wr_ch(wr_ch), .wr_step(wr_step), .wr_note(wr_note),
    .wr_gate(wr_gate), .transpose(transpose), .note_out(note_out),
    .gate_out(gate_out), .step_idx(step_idx), .step_pulse(step_pulse),
    .beat_led(beat_led)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  int m_gate_mem [NUM_CH][STEPS];
  int m_note_mem [NUM_CH][STEPS];
  int m_cnt, m_step, m_pulse, m_beat, m_was_running;
  int m_note [NUM_CH];
  int m_gate [NUM_CH];

  function automatic int model_load(int n, int c);
    int v;
    logic signed [5:0] t;
    t = transpose[c*6 +: 6];
    v = n;
`ifdef TRANSPOSE_EN
    if (n != 0) begin
      v = n + int'(t);
      if (v < 1)  v = 1;
      if (v > 63) v = 63;
    end
`endif
    return v;
  endfunction

  function automatic int model_next();
    return (m_step >= int'(last_step)) ? 0 : m_step + 1;
  endfunction

  function automatic bit model_fires();
    return run && (m_cnt >= int'(tempo_div));
  endfunction

  task automatic model_edge();
    int nxt;
    bit fire;
    if (rst) begin
      m_cnt = 0; m_step = 0; m_pulse = 0; m_beat = 0; m_was_running = 0;
      for (int c = 0; c < NUM_CH; c++) begin
        m_note[c] = 0; m_gate[c] = 0;
        for (int s = 0; s < STEPS; s++) begin
          m_gate_mem[c][s] = 0; m_note_mem[c][s] = 0;
        end
      end
      return;
    end
    fire = model_fires();
    nxt  = model_next();
    m_pulse = fire ? 1 : 0;
    if (fire) begin
      m_step = nxt;
      m_beat = 1 - m_beat;
      for (int c = 0; c < NUM_CH; c++) begin
        m_gate[c] = m_gate_mem[c][nxt];
        if (m_gate[c] == 1) m_note[c] = model_load(m_note_mem[c][nxt], c);
      end
    end else if (!run) begin
      for (int c = 0; c < NUM_CH; c++) m_gate[c] = 0;
    end else if (m_was_running == 0) begin
      for (int c = 0; c < NUM_CH; c++) m_gate[c] = m_gate_mem[c][m_step];
    end
    if (run) m_cnt = fire ? 0 : m_cnt + 1;
    m_was_running = run ? 1 : 0;
    // Writes land after the load, so a same-cycle load sees the old entry
    if (wr_en && int'(wr_ch) < NUM_CH) begin
      m_gate_mem[wr_ch][wr_step] = wr_gate ? 1 : 0;
      m_note_mem[wr_ch][wr_step] = int'(wr_note);
    end
  endtask

  task automatic tick();
    logic [NUM_CH*NOTE_W-1:0] en;
    logic [NUM_CH-1:0]        eg;
    @(posedge clk);
    model_edge();
    #1;
    for (int c = 0; c < NUM_CH; c++) begin
      en[c*NOTE_W +: NOTE_W] = NOTE_W'(m_note[c]);
      eg[c] = (m_gate[c] != 0);
    end
    check("step_idx", 64'(step_idx), 64'(m_step));
    check("note_out", 64'(note_out), 64'(en));
    check("gate_out", 64'(gate_out), 64'(eg));
    check("step_pulse", 64'(step_pulse), 64'(m_pulse));
    check("beat_led", 64'(beat_led), 64'(m_beat));
  endtask

  task automatic write_entry(input int ch, input int st, input int g, input int n);
    wr_en = 1'b1; wr_ch = 2'(ch); wr_step = 4'(st); wr_gate = g[0]; wr_note = 6'(n);
    tick();
    wr_en = 1'b0;
  endtask

  initial begin
    int k;
    rst = 1'b1; run = 1'b0; tempo_div = '0; last_step = 4'd15; wr_en = 1'b0;
    wr_ch = '0; wr_step = '0; wr_note = '0; wr_gate = 1'b0; transpose = '0;
    tick(); tick();
    rst = 1'b0;

    // Empty pattern, step every 4 clocks across a full wrap
    tempo_div = 24'd3; run = 1'b1;
    repeat (70) tick();

    // Gate on then gate off at the next step; ch1 step 2 holds 13
    write_entry(0, 1, 1, 41);
    write_entry(0, 2, 0, 7);
    write_entry(1, 2, 1, 13);
    repeat (70) tick();

    // Shrink the loop while sitting past its new end
    k = 0;
    while (m_step != 10 && k < 100) begin tick(); k++; end
    check("wait_step10", 64'(m_step == 10), 64'd1);
    last_step = 4'd3;
    repeat (40) tick();

    // Pause just after arriving at step 5, then resume
    last_step = 4'd15;
    k = 0;
    while (!(m_step == 5 && m_pulse == 1) && k < 100) begin tick(); k++; end
    check("wait_step5", 64'(m_step == 5), 64'd1);
    run = 1'b0;
    repeat (20) tick();
    check("pause_step", 64'(step_idx), 64'd5);
    run = 1'b1;
    repeat (20) tick();

    // Overwrite ch1 step 2 on the very cycle it is being loaded
    k = 0;
    while (!(model_fires() && model_next() == 2) && k < 100) begin tick(); k++; end
    check("wait_load2", 64'(model_next() == 2), 64'd1);
    write_entry(1, 2, 1, 25);
    check("collide_old", 64'(note_out[11:6]), 64'd13);
    repeat (70) tick();

    // Fast stepping with transpose offsets over a short loop
    write_entry(0, 0, 1, 60);
    write_entry(0, 1, 1, 5);
    write_entry(0, 2, 1, 0);
    write_entry(0, 3, 1, 30);
    last_step = 4'd3; tempo_div = '0;
    transpose[5:0] = 6'd12;
    repeat (8) tick();
    transpose[5:0] = 6'h38;
    repeat (8) tick();

    // Randomized operation
    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(0, 499) == 0);
      run   = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 39) == 0) tempo_div = DIV_W'($urandom_range(0, 5));
      if ($urandom_range(0, 39) == 0) last_step = STEP_W'($urandom_range(0, 15));
      if ($urandom_range(0, 19) == 0) transpose = 24'($urandom);
      wr_en   = ($urandom_range(0, 3) == 0);
      wr_ch   = 2'($urandom);
      wr_step = 4'($urandom);
      wr_note = 6'($urandom);
      wr_gate = ($urandom_range(0, 2) != 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/step_sequencer.md
Name: step_sequencer

Overview:
Programmable multi-channel step sequencer that replaces hard-coded demo note patterns with a writable pattern memory. It holds NUM_CH x STEPS entries of {gate, note}. It advances one step every (tempo_div+1) clocks while run is high, and drives per-channel note numbers and gates into the base_freq_genx64 / square_gen / trigen channels.

Parameters:
NUM_CH, 4, number of voice channels
NOTE_W, 6, note number width (note 0 = rest)
STEPS, 16, pattern depth (power of 2)
STEP_W, 4, log2(STEPS)
DIV_W, 24, tempo divider width

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
run  in  1  1 = sequencer advancing; 0 = paused
tempo_div  in  DIV_W  clocks per step minus 1
last_step  in  STEP_W  index of final step before wrap
wr_en  in  1  pattern write strobe
wr_ch  in  log2(NUM_CH)  channel to write
wr_step  in  STEP_W  step to write
wr_note  in  NOTE_W  note to store
wr_gate  in  1  gate to store
transpose  in  NUM_CH*6  per-channel signed semitone offset (used only with TRANSPOSE_EN)
note_out  out  NUM_CH*NOTE_W  per-channel note, channel 0 in LSBs
gate_out  out  NUM_CH  per-channel gate (drives channel en)
step_idx  out  STEP_W  current step
step_pulse  out  1  one-cycle strobe on each step advance
beat_led  out  1  toggles on every step advance

Behaviour:
- Single clock domain. All outputs are registered.
- Reset (rst=1, synchronous) sets step_idx=0, tick counter=0, note_out=0, gate_out=0, step_pulse=0, beat_led=0, and clears every pattern entry to {gate=0, note=0}. rst has priority over all other inputs, including wr_en.
- Tick counter: while run=1, it increments each cycle. When counter >= tempo_div, the "advance" event fires and counter returns to 0 on the next cycle.
  - The >= comparison means lowering tempo_div mid-step fires on the next cycle.
  - tempo_div=0 advances every cycle.
- Advance: next = (step_idx >= last_step) ? 0 : step_idx+1.
  - On the cycle after advance: step_idx=next, step_pulse=1, beat_led toggles.
  - Per channel c: gate_out[c]=mem[c][next].gate. If that gate=1, note_out[c]=mem[c][next].note; otherwise note_out[c] holds its previous value (note sustains for glide/porta, gate drops).
- last_step changed below the current step_idx: the next advance wraps to 0.
- Pause (run=0): counter, step_idx and note_out hold; gate_out forced to 0 the next cycle; step_pulse=0.
- Run 0->1: counter restarts from its held value and gates are restored from mem[c][step_idx] the next cycle. No step advance is implied.
- Write: when wr_en=1, mem[wr_ch][wr_step] <= {wr_gate, wr_note} at the clock edge.
  - If an advance loads the same entry in the same cycle, the load uses the pre-write contents.
  - Writing the current step does not alter outputs until that step is next loaded.
- Out-of-range wr_ch (>= NUM_CH): the write is ignored.
- Output latency: pattern memory to note_out/gate_out is 1 cycle after the advance event.

Optional Feature:
TRANSPOSE_EN
- Defined: each loaded note n != 0 becomes n + transpose[c] (6-bit two's complement), saturated to the range 1..2^NOTE_W-1. Note 0 (rest) is never transposed. transpose is sampled at load time only.
- Undefined: the transpose port is present but ignored; notes pass through unchanged.

Test Plan:
- Reset then run=1, tempo_div=3, last_step=15, empty pattern -> step_pulse every 4 cycles; step_idx sequence 1,2,...,15,0; gate_out=0, note_out=0 throughout.
- Write ch0 step1 {1,41} and ch0 step2 {0,x}, run -> at step 1: note_out[5:0]=41, gate_out[0]=1; at step 2: note_out holds 41, gate_out[0]=0.
- last_step=3 with step_idx=10 -> next advance gives step_idx=0, then 1,2,3,0.
- Pause run=0 at step 5 for 20 cycles -> step_idx=5, gate_out=0, notes unchanged. Resume -> gates restored in 1 cycle; advance after the remaining tick count.
- Write to the entry being loaded on the advance cycle (ch1 step 2, old {1,13}, new {1,25}) -> outputs show 13; the next pass through step 2 shows 25.
- TRANSPOSE_EN, transpose[0]=+12 with note 60 -> 63 (saturated). transpose[0]=-8 with note 5 -> 1. Note 0 -> stays 0.
